// File: rtl/adc_set_router_pkg.sv
// Shared definitions for the ADC channel set router.
// Contents:
//   mode_e          - output mode encodings on the 2-bit mode port
//   state_e         - map-switch FSM state encodings
//   reset_map_index - source channel for output k in the map that is
//                     loaded at reset (identity or reversed)
`timescale 1ns/1ps
package adc_set_router_pkg;

    typedef enum logic [1:0] {
        MODE_ROUTE    = 2'd0,
        MODE_ZERO     = 2'd1,
        MODE_RAMP     = 2'd2,
        MODE_ZERO_ALT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

    function automatic int reset_map_index(input int k, input int count, input bit reverse);
        int idx;
        if (reverse) begin
            idx = count - 32'sd1 - k;
        end else begin
            idx = k;
        end
        return idx;
    endfunction

endpackage

// File: rtl/adc_map_check.sv
// Combinational validation of a routing map.
// A map is legal when every field addresses an existing channel and no two
// fields name the same source channel (the map must be a permutation).
// Ports:
//   map_fields [CHANNEL_COUNT*SEL_WIDTH] - flat map, field k in bits k*SEL_WIDTH
//   map_valid                            - high when the map is legal
`timescale 1ns/1ps
module adc_map_check
    import adc_set_router_pkg::*;
#(
    parameter int CHANNEL_COUNT = 8,
    parameter int SEL_WIDTH     = $clog2(CHANNEL_COUNT)
) (
    input  logic [CHANNEL_COUNT*SEL_WIDTH-1:0] map_fields,
    output logic                               map_valid
);

    logic map_ok_s;

    // Range check on every field plus pairwise duplicate check.
    always_comb begin
        map_ok_s = 1'b1;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            if (32'(map_fields[i*SEL_WIDTH +: SEL_WIDTH]) >= 32'(CHANNEL_COUNT)) begin
                map_ok_s = 1'b0;
            end else begin
                map_ok_s = map_ok_s;
            end
            for (int j = i + 1; j < CHANNEL_COUNT; j++) begin
                if (map_fields[i*SEL_WIDTH +: SEL_WIDTH] == map_fields[j*SEL_WIDTH +: SEL_WIDTH]) begin
                    map_ok_s = 1'b0;
                end else begin
                    map_ok_s = map_ok_s;
                end
            end
        end
    end

    assign map_valid = map_ok_s;

endmodule

// File: rtl/adc_set_router.sv
// ADC channel set router with timing-event synchronised map switching.
// A new map is staged with mapLoad and becomes active on the next
// syncStrobe; after a switch, BLANK_CYCLES words are marked invalid so
// downstream sees a clean break between the old and new channel sets.
// Optional feature macro: ADC_SET_ROUTER_TEST_PATTERN_EN (mode 2 ramp).
// Ports:
//   adcClk, adcReset (sync, active high)
//   adcData/adcValid            - flat input channel bus and qualifier
//   mapStage/mapLoad/syncStrobe - staged map, load strobe, switch strobe
//   mode                        - 0 route, 1/3 zero, 2 ramp (or zero)
//   routedData/routedValid      - output bus, 2 cycles after input
//   armed, mapError, loadRejected, switchCount - status
`timescale 1ns/1ps
module adc_set_router
    import adc_set_router_pkg::*;
#(
    parameter int    CHANNEL_COUNT     = 8,
    parameter int    DATA_WIDTH        = 32,
    parameter int    SEL_WIDTH         = $clog2(CHANNEL_COUNT),
    parameter int    BLANK_CYCLES      = 4,
    parameter string RESET_MAP_REVERSE = "FALSE"
) (
    input  logic                                adcClk,
    input  logic                                adcReset,
    input  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] adcData,
    input  logic                                adcValid,
    input  logic [CHANNEL_COUNT*SEL_WIDTH-1:0]  mapStage,
    input  logic                                mapLoad,
    input  logic                                syncStrobe,
    input  logic [1:0]                          mode,
    output logic [CHANNEL_COUNT*DATA_WIDTH-1:0] routedData,
    output logic                                routedValid,
    output logic                                armed,
    output logic                                mapError,
    output logic                                loadRejected,
    output logic [15:0]                         switchCount
);

    localparam int BUS_W       = CHANNEL_COUNT * DATA_WIDTH;
    localparam int MAP_W       = CHANNEL_COUNT * SEL_WIDTH;
    localparam bit REVERSE_MAP = (RESET_MAP_REVERSE == "TRUE");

    state_e             state_r;
    logic [MAP_W-1:0]   pending_r;
    logic [MAP_W-1:0]   active_r;
    logic [7:0]         blank_cnt_r;
    logic [15:0]        switch_count_r;
    logic               armed_r;
    logic               map_error_r;
    logic               load_rejected_r;
    logic [BUS_W-1:0]   s1_data_r;
    logic               s1_valid_r;
    logic [BUS_W-1:0]   routed_data_r;
    logic               routed_valid_r;

    logic [MAP_W-1:0]   reset_map_s;
    logic               map_ok_s;
    logic [BUS_W-1:0]   routed_s;
    logic [BUS_W-1:0]   stage_data_s;

    adc_map_check #(
        .CHANNEL_COUNT (CHANNEL_COUNT),
        .SEL_WIDTH     (SEL_WIDTH)
    ) u_map_check (
        .map_fields (mapStage),
        .map_valid  (map_ok_s)
    );

    // Map put in force by reset (identity or reversed).
    always_comb begin
        reset_map_s = {MAP_W{1'b0}};
        for (int k = 0; k < CHANNEL_COUNT; k++) begin
            reset_map_s[k*SEL_WIDTH +: SEL_WIDTH] =
                SEL_WIDTH'(reset_map_index(k, CHANNEL_COUNT, REVERSE_MAP));
        end
    end

    // Crossbar: output channel k takes input channel active_r[k].
    always_comb begin
        routed_s = {BUS_W{1'b0}};
        for (int k = 0; k < CHANNEL_COUNT; k++) begin
            routed_s[k*DATA_WIDTH +: DATA_WIDTH] =
                adcData[int'(active_r[k*SEL_WIDTH +: SEL_WIDTH])*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef ADC_SET_ROUTER_TEST_PATTERN_EN
    logic [DATA_WIDTH-1:0] ramp_r;
    logic [BUS_W-1:0]      ramp_data_s;

    // Ramp pattern: channel k carries counter + k.
    always_comb begin
        ramp_data_s = {BUS_W{1'b0}};
        for (int k = 0; k < CHANNEL_COUNT; k++) begin
            ramp_data_s[k*DATA_WIDTH +: DATA_WIDTH] = ramp_r + DATA_WIDTH'(k);
        end
    end

    // Ramp counter advances once per qualified input word.
    always_ff @(posedge adcClk) begin
        if (adcReset) begin
            ramp_r <= {DATA_WIDTH{1'b0}};
        end else if (adcValid) begin
            ramp_r <= ramp_r + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            ramp_r <= ramp_r;
        end
    end
`endif

    // Mode selection for the word entering the first pipeline stage.
    always_comb begin
        stage_data_s = {BUS_W{1'b0}};
        case (mode_e'(mode))
            MODE_ROUTE:    stage_data_s = routed_s;
            MODE_ZERO:     stage_data_s = {BUS_W{1'b0}};
`ifdef ADC_SET_ROUTER_TEST_PATTERN_EN
            MODE_RAMP:     stage_data_s = ramp_data_s;
`else
            MODE_RAMP:     stage_data_s = {BUS_W{1'b0}};
`endif
            MODE_ZERO_ALT: stage_data_s = {BUS_W{1'b0}};
            default:       stage_data_s = {BUS_W{1'b0}};
        endcase
    end

    // Map-switch FSM with registered status outputs.
    always_ff @(posedge adcClk) begin
        if (adcReset) begin
            state_r         <= ST_IDLE;
            pending_r       <= reset_map_s;
            active_r        <= reset_map_s;
            blank_cnt_r     <= 8'd0;
            switch_count_r  <= 16'd0;
            armed_r         <= 1'b0;
            map_error_r     <= 1'b0;
            load_rejected_r <= 1'b0;
        end else begin
            map_error_r     <= 1'b0;
            load_rejected_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (mapLoad) begin
                        if (map_ok_s) begin
                            pending_r <= mapStage;
                            state_r   <= ST_ARMED;
                            armed_r   <= 1'b1;
                        end else begin
                            map_error_r <= 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    // A load in the same cycle as the strobe wins over the switch.
                    if (mapLoad) begin
                        if (map_ok_s) begin
                            pending_r <= mapStage;
                        end else begin
                            map_error_r <= 1'b1;
                        end
                    end else if (syncStrobe) begin
                        active_r       <= pending_r;
                        switch_count_r <= switch_count_r + 16'd1;
                        state_r        <= ST_BLANK;
                        armed_r        <= 1'b0;
                        blank_cnt_r    <= 8'(BLANK_CYCLES - 1);
                    end
                end
                ST_BLANK: begin
                    if (mapLoad) begin
                        load_rejected_r <= 1'b1;
                    end
                    if (blank_cnt_r == 8'd0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        blank_cnt_r <= blank_cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    armed_r <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage data pipeline. Blanking is applied to words sampled while
    // in BLANK, so exactly BLANK_CYCLES output words are suppressed and the
    // first words through the new map are the ones dropped.
    always_ff @(posedge adcClk) begin
        if (adcReset) begin
            s1_data_r      <= {BUS_W{1'b0}};
            s1_valid_r     <= 1'b0;
            routed_data_r  <= {BUS_W{1'b0}};
            routed_valid_r <= 1'b0;
        end else begin
            s1_data_r      <= stage_data_s;
            s1_valid_r     <= adcValid & (state_r != ST_BLANK);
            routed_data_r  <= s1_data_r;
            routed_valid_r <= s1_valid_r;
        end
    end

    assign routedData   = routed_data_r;
    assign routedValid  = routed_valid_r;
    assign armed        = armed_r;
    assign mapError     = map_error_r;
    assign loadRejected = load_rejected_r;
    assign switchCount  = switch_count_r;

endmodule

// File: tb/tb_adc_set_router.sv
`timescale 1ns/1ps
module tb_adc_set_router;

    localparam int CC = 8;
    localparam int DW = 32;
    localparam int SW = 3;
    localparam int BC = 4;

    logic              adcClk = 1'b0;
    logic              adcReset;
    logic [CC*DW-1:0]  adcData;
    logic              adcValid;
    logic [CC*SW-1:0]  mapStage;
    logic              mapLoad;
    logic              syncStrobe;
    logic [1:0]        mode;
    logic [CC*DW-1:0]  routedData;
    logic              routedValid;
    logic              armed;
    logic              mapError;
    logic              loadRejected;
    logic [15:0]       switchCount;

    int errors = 0;
    int checks = 0;

    // reference model state
    int               act[CC];
    int               pend[CC];
    bit               m_armed;
    int               blank_left;
    int               sw_cnt;
    bit               m_err;
    bit               m_rej;
    logic [CC*DW-1:0] exp_d1, exp_d2;
    bit               exp_v1, exp_v2;
`ifdef ADC_SET_ROUTER_TEST_PATTERN_EN
    logic [DW-1:0]    ramp;
`endif

    always #5 adcClk = ~adcClk;

    adc_set_router #(
        .CHANNEL_COUNT     (CC),
        .DATA_WIDTH        (DW),
        .SEL_WIDTH         (SW),
        .BLANK_CYCLES      (BC),
        .RESET_MAP_REVERSE ("TRUE")
    ) dut (
        .adcClk       (adcClk),
        .adcReset     (adcReset),
        .adcData      (adcData),
        .adcValid     (adcValid),
        .mapStage     (mapStage),
        .mapLoad      (mapLoad),
        .syncStrobe   (syncStrobe),
        .mode         (mode),
        .routedData   (routedData),
        .routedValid  (routedValid),
        .armed        (armed),
        .mapError     (mapError),
        .loadRejected (loadRejected),
        .switchCount  (switchCount)
    );

    // legal = permutation of 0..CC-1 (occurrence counting)
    function automatic bit map_legal(input logic [CC*SW-1:0] m);
        int seen[CC];
        int idx;
        for (int i = 0; i < CC; i++) seen[i] = 0;
        for (int k = 0; k < CC; k++) begin
            idx = int'(m[k*SW +: SW]);
            if (idx >= CC) return 1'b0;
            seen[idx]++;
            if (seen[idx] > 1) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic make_perm(output logic [CC*SW-1:0] m);
        int p[CC];
        int j, t;
        for (int i = 0; i < CC; i++) p[i] = i;
        for (int i = CC - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = p[i]; p[i] = p[j]; p[j] = t;
        end
        for (int k = 0; k < CC; k++) m[k*SW +: SW] = 3'(p[k]);
    endtask

    task automatic set_data_rand();
        for (int k = 0; k < CC; k++) adcData[k*DW +: DW] = $urandom;
    endtask

    task automatic set_data_idx(input int base);
        for (int k = 0; k < CC; k++) adcData[k*DW +: DW] = 32'(base + k);
    endtask

    // Advance one clock: update the model from the inputs the DUT samples
    // at this edge, then wait until just after the edge.
    task automatic step();
        logic [CC*DW-1:0] word;
        bit ok;
        word = '0;
        for (int k = 0; k < CC; k++) begin
            case (mode)
                2'd0: word[k*DW +: DW] = adcData[act[k]*DW +: DW];
`ifdef ADC_SET_ROUTER_TEST_PATTERN_EN
                2'd2: word[k*DW +: DW] = ramp + 32'(k);
`endif
                default: word[k*DW +: DW] = 32'd0;
            endcase
        end
        ok = map_legal(mapStage);
        if (adcReset) begin
            for (int k = 0; k < CC; k++) begin
                act[k] = CC - 1 - k;
                pend[k] = CC - 1 - k;
            end
            m_armed = 0; blank_left = 0; sw_cnt = 0; m_err = 0; m_rej = 0;
            exp_d1 = '0; exp_d2 = '0; exp_v1 = 0; exp_v2 = 0;
`ifdef ADC_SET_ROUTER_TEST_PATTERN_EN
            ramp = '0;
`endif
        end else begin
            exp_d2 = exp_d1; exp_v2 = exp_v1;
            exp_d1 = word;   exp_v1 = adcValid && (blank_left == 0);
`ifdef ADC_SET_ROUTER_TEST_PATTERN_EN
            if (adcValid) ramp = ramp + 32'd1;
`endif
            m_err = 0; m_rej = 0;
            if (blank_left > 0) begin
                if (mapLoad) m_rej = 1;
                blank_left--;
            end else if (mapLoad && !ok) begin
                m_err = 1;
            end else if (mapLoad) begin
                for (int k = 0; k < CC; k++) pend[k] = int'(mapStage[k*SW +: SW]);
                m_armed = 1;
            end else if (m_armed && syncStrobe) begin
                act = pend;
                sw_cnt = (sw_cnt + 1) % 65536;
                m_armed = 0;
                blank_left = BC;
            end
        end
        @(posedge adcClk);
        #1;
    endtask

    task automatic test_reset();
        adcReset = 1; mode = 2'd0; adcValid = 1; mapLoad = 0; syncStrobe = 0;
        mapStage = '0; set_data_idx(0);
        step(); step();
        checks++; if (routedValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", routedValid); end
        checks++; if (routedData !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", routedData); end
        checks++; if (armed !== 1'b0 || mapError !== 1'b0 || loadRejected !== 1'b0) begin
            errors++; $display("FAIL reset_status: got armed=%0b err=%0b rej=%0b expected 0", armed, mapError, loadRejected); end
        checks++; if (switchCount !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", switchCount); end
        adcReset = 0;
        step(); step();
        for (int k = 0; k < CC; k++) begin
            checks++;
            if (routedData[k*DW +: DW] !== 32'(CC - 1 - k)) begin
                errors++; $display("FAIL reverse_map ch%0d: got %0d expected %0d", k, routedData[k*DW +: DW], CC - 1 - k); end
        end
        checks++; if (routedValid !== 1'b1) begin errors++; $display("FAIL reverse_valid: got %0b expected 1", routedValid); end
    endtask

    task automatic test_switch();
        int low;
        set_data_idx(32'h100);
        for (int k = 0; k < CC; k++) mapStage[k*SW +: SW] = 3'(k ^ 1);
        mapLoad = 1; step(); mapLoad = 0;
        for (int n = 0; n < 3; n++) begin
            checks++; if (armed !== 1'b1) begin errors++; $display("FAIL armed_cycle%0d: got %0b expected 1", n, armed); end
            if (n < 2) step();
        end
        syncStrobe = 1; step(); syncStrobe = 0;
        checks++; if (armed !== 1'b0) begin errors++; $display("FAIL armed_after_switch: got %0b expected 0", armed); end
        checks++; if (switchCount !== 16'd1) begin errors++; $display("FAIL switch_count1: got %0d expected 1", switchCount); end
        low = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (!routedValid) low++;
            checks++; if (routedData !== exp_d2) begin errors++; $display("FAIL switch_data step%0d: got %0h expected %0h", n, routedData, exp_d2); end
        end
        checks++; if (low !== 4) begin errors++; $display("FAIL blank_len: got %0d expected 4", low); end
        for (int k = 0; k < CC; k++) begin
            checks++;
            if (routedData[k*DW +: DW] !== 32'(32'h100 + (k ^ 1))) begin
                errors++; $display("FAIL new_map ch%0d: got %0h expected %0h", k, routedData[k*DW +: DW], 32'h100 + (k ^ 1)); end
        end
    endtask

    task automatic test_bad_map();
        for (int k = 0; k < CC; k++) mapStage[k*SW +: SW] = 3'(k);
        mapStage[1*SW +: SW] = 3'd5;
        mapLoad = 1; step(); mapLoad = 0;
        checks++; if (mapError !== 1'b1) begin errors++; $display("FAIL dup_error: got %0b expected 1", mapError); end
        checks++; if (armed !== 1'b0) begin errors++; $display("FAIL dup_armed: got %0b expected 0", armed); end
        step();
        checks++; if (mapError !== 1'b0) begin errors++; $display("FAIL dup_pulse: got %0b expected 0", mapError); end
        step(); step();
        for (int k = 0; k < CC; k++) begin
            checks++;
            if (routedData[k*DW +: DW] !== 32'(32'h100 + (k ^ 1))) begin
                errors++; $display("FAIL dup_map_kept ch%0d: got %0h expected %0h", k, routedData[k*DW +: DW], 32'h100 + (k ^ 1)); end
        end
    endtask

    task automatic test_load_vs_sync();
        logic [CC*SW-1:0] a;
        make_perm(a);
        set_data_rand(); mapStage = a; mapLoad = 1; step();
        set_data_rand(); make_perm(mapStage); syncStrobe = 1; step();
        checks++; if (armed !== 1'b1) begin errors++; $display("FAIL collide_armed: got %0b expected 1", armed); end
        checks++; if (switchCount !== 16'd1) begin errors++; $display("FAIL collide_count: got %0d expected 1", switchCount); end
        set_data_rand(); mapLoad = 0; step();
        checks++; if (switchCount !== 16'd2) begin errors++; $display("FAIL second_switch: got %0d expected 2", switchCount); end
        set_data_rand(); syncStrobe = 0; mapStage = a; mapLoad = 1; step(); mapLoad = 0;
        checks++; if (loadRejected !== 1'b1) begin errors++; $display("FAIL blank_reject: got %0b expected 1", loadRejected); end
        set_data_rand(); step();
        checks++; if (loadRejected !== 1'b0) begin errors++; $display("FAIL reject_pulse: got %0b expected 0", loadRejected); end
        for (int n = 0; n < 6; n++) begin
            set_data_rand(); step();
            checks++; if (routedData !== exp_d2 || routedValid !== exp_v2) begin
                errors++; $display("FAIL collide_data step%0d: got %0b/%0h expected %0b/%0h", n, routedValid, routedData, exp_v2, exp_d2); end
        end
        checks++; if (armed !== 1'b0) begin errors++; $display("FAIL reject_no_arm: got %0b expected 0", armed); end
    endtask

    task automatic test_reset_armed();
        adcReset = 1; step(); adcReset = 0;
        set_data_idx(0);
        for (int k = 0; k < CC; k++) mapStage[k*SW +: SW] = 3'(k ^ 1);
        mapLoad = 1; step(); mapLoad = 0;
        checks++; if (armed !== 1'b1) begin errors++; $display("FAIL pre_reset_armed: got %0b expected 1", armed); end
        adcReset = 1; step(); adcReset = 0;
        syncStrobe = 1; step(); syncStrobe = 0;
        checks++; if (switchCount !== 16'd0 || armed !== 1'b0) begin
            errors++; $display("FAIL reset_abandon: got count=%0d armed=%0b expected 0/0", switchCount, armed); end
        step(); step();
        for (int k = 0; k < CC; k++) begin
            checks++;
            if (routedData[k*DW +: DW] !== 32'(CC - 1 - k)) begin
                errors++; $display("FAIL reset_map ch%0d: got %0d expected %0d", k, routedData[k*DW +: DW], CC - 1 - k); end
        end
    endtask

    task automatic test_mode();
        logic [DW-1:0] want;
        adcReset = 1; step(); adcReset = 0;
        mode = 2'd2;
        for (int n = 0; n <= 10; n++) begin
            set_data_rand(); adcValid = (n < 10);
            step();
            if (n >= 1) begin
`ifdef ADC_SET_ROUTER_TEST_PATTERN_EN
                want = 32'(n + 2);
`else
                want = 32'd0;
`endif
                checks++; if (routedData[3*DW +: DW] !== want || routedValid !== 1'b1) begin
                    errors++; $display("FAIL ramp ch3 step%0d: got %0h/%0b expected %0h/1", n, routedData[3*DW +: DW], routedValid, want); end
            end
        end
        for (int n = 0; n < 12; n++) begin
            mode = (n < 6) ? 2'd1 : 2'd3;
            set_data_rand(); adcValid = ($urandom_range(1, 0) == 1);
            step();
            checks++; if (routedData !== exp_d2 || routedValid !== exp_v2) begin
                errors++; $display("FAIL zero_mode step%0d: got %0b/%0h expected %0b/%0h", n, routedValid, routedData, exp_v2, exp_d2); end
        end
        mode = 2'd0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_data_rand();
            adcValid   = ($urandom_range(3, 0) != 0);
            adcReset   = ($urandom_range(99, 0) == 0);
            syncStrobe = ($urandom_range(3, 0) == 0);
            mapLoad    = ($urandom_range(5, 0) == 0);
            if ($urandom_range(3, 0) != 0) make_perm(mapStage);
            else mapStage = CC*SW'($urandom);
            if ($urandom_range(7, 0) == 0) mode = 2'($urandom);
            step();
            checks++; if (routedData !== exp_d2 || routedValid !== exp_v2) begin
                errors++; $display("FAIL rand_data step%0d: got %0b/%0h expected %0b/%0h", n, routedValid, routedData, exp_v2, exp_d2); end
            checks++; if (armed !== m_armed || mapError !== m_err || loadRejected !== m_rej) begin
                errors++; $display("FAIL rand_status step%0d: got %0b%0b%0b expected %0b%0b%0b", n, armed, mapError, loadRejected, m_armed, m_err, m_rej); end
            checks++; if (switchCount !== 16'(sw_cnt)) begin
                errors++; $display("FAIL rand_count step%0d: got %0d expected %0d", n, switchCount, sw_cnt); end
        end
        adcReset = 0; mapLoad = 0; syncStrobe = 0;
    endtask

    initial begin
        test_reset();
        test_switch();
        test_bad_map();
        test_load_vs_sync();
        test_reset_armed();
        test_mode();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_set_router.md
ADC_SET_ROUTER -- requirements
Module: adc_set_router

Interface
REQ-001 SHALL have parameter CHANNEL_COUNT, default 8, number of ADC channels routed (power of two, 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bits per channel word (I/Q sample pair).
REQ-003 SHALL have parameter SEL_WIDTH, default $clog2(CHANNEL_COUNT), bits per routing index.
REQ-004 SHALL have parameter BLANK_CYCLES, default 4, cycles with output valid suppressed after a map switch (1..255).
REQ-005 SHALL have parameter RESET_MAP_REVERSE, default "FALSE", giving the map in force after reset: "FALSE" identity, "TRUE" reversed.
REQ-006 SHALL have ports: adcClk in 1, sole clock; adcReset in 1, synchronous active-high reset.
REQ-007 SHALL have ports: adcData in CHANNEL_COUNT*DATA_WIDTH, flat channel bus, channel 0 in LSBs; adcValid in 1, word qualifier.
REQ-008 SHALL have ports: mapStage in CHANNEL_COUNT*SEL_WIDTH, staged map, field k = source channel for output k; mapLoad in 1, single-cycle load strobe; syncStrobe in 1, single-cycle timing-event strobe (EVR heartbeat).
REQ-009 SHALL have ports: mode in 2, 0 route, 1 zero, 2 ramp, 3 treated as 1.
REQ-010 SHALL have ports: routedData out CHANNEL_COUNT*DATA_WIDTH; routedValid out 1; armed out 1; mapError out 1, one-cycle pulse; loadRejected out 1, one-cycle pulse; switchCount out 16.

Function
REQ-011 SHALL run FSM states IDLE, ARMED, BLANK.
REQ-012 In IDLE, a valid mapLoad SHALL latch mapStage into the pending map and move to ARMED next cycle.
REQ-013 In ARMED, a valid mapLoad SHALL overwrite the pending map and stay ARMED; syncStrobe alone SHALL copy pending to active, increment switchCount (wrapping 0xFFFF->0), and enter BLANK.
REQ-014 On simultaneous mapLoad and syncStrobe in ARMED, the load SHALL win: pending updated, no switch, stay ARMED.
REQ-015 syncStrobe in IDLE or BLANK SHALL be ignored.
REQ-016 BLANK SHALL hold routedValid low for exactly BLANK_CYCLES cycles, then go to IDLE.
REQ-017 mapLoad in BLANK SHALL be dropped and loadRejected pulsed.
REQ-018 A map with any duplicate index or any index >= CHANNEL_COUNT SHALL be rejected: mapError pulsed, no state or map change.
REQ-019 armed SHALL be high exactly in ARMED.
REQ-020 Data path SHALL be two registered stages: routedData/routedValid follow adcData/adcValid by 2 cycles; routedData channel k = adcData channel active[k].
REQ-021 The active map SHALL change only at the switch edge; no output word mixes old and new maps.
REQ-022 mode 1 SHALL drive routedData to zero with routedValid unchanged; mode changes SHALL take effect with the same 2-cycle latency.

Reset
REQ-023 adcReset SHALL force IDLE, active and pending maps to the RESET_MAP_REVERSE map, routedData 0, routedValid 0, armed 0, mapError 0, loadRejected 0, switchCount 0, ramp counter 0.
REQ-024 Reset asserted mid-BLANK or mid-ARMED SHALL abandon the pending map with no switch counted.

Configuration
REQ-025 With ADC_SET_ROUTER_TEST_PATTERN_EN defined, mode 2 SHALL output channel k = ramp counter + k (DATA_WIDTH, wrapping); the counter increments per adcValid.
REQ-026 Without ADC_SET_ROUTER_TEST_PATTERN_EN, mode 2 SHALL behave as mode 1 and no ramp counter SHALL be built.

Structure
REQ-027 Mode encodings, FSM state encodings and the reset-map function SHALL live in shared package adc_set_router_pkg.
REQ-028 Map validation (duplicate/range check) SHALL be sub-module adc_map_check, combinational, one output valid flag.

Verification
REQ-029 Reset, CHANNEL_COUNT=8, RESET_MAP_REVERSE="TRUE", channel i = i, adcValid=1 -> after 2 cycles output k = 7-k, switchCount=0.
REQ-030 Load map {1,0,3,2,5,4,7,6}, syncStrobe 3 cycles later -> armed high 3 cycles, routedValid low exactly 4 cycles, then output k = input map[k], switchCount=1.
REQ-031 Load map with index 5 twice -> mapError one pulse, armed stays 0, output map unchanged.
REQ-032 mapLoad and syncStrobe same cycle in ARMED -> no switch, new pending map; next syncStrobe switches to it; mapLoad during BLANK -> loadRejected pulse.
REQ-033 adcReset asserted in ARMED, then syncStrobe -> no switch, switchCount=0, reset map in force.
REQ-034 With ADC_SET_ROUTER_TEST_PATTERN_EN, mode=2, 10 valid cycles -> channel 3 output = 3..12; without it -> all zero.
